// File: rtl/tcp_msg_poll_sched.sv
// tcp_msg_poll_sched: round-robin per-flow scheduler that notifies once enough bytes are buffered
module tcp_msg_poll_sched #(
    parameter int FLOWID_W  = 3,
    parameter int REQ_PTR_W = 16,
    parameter int XY_WIDTH  = 8,
    parameter int FBITS_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_wr_val,
    input  logic [FLOWID_W-1:0]  req_wr_flowid,
    input  logic [REQ_PTR_W-1:0] req_wr_len,
    input  logic [XY_WIDTH-1:0]  req_wr_dst_x,
    input  logic [XY_WIDTH-1:0]  req_wr_dst_y,
    input  logic [FBITS_W-1:0]   req_wr_dst_fbits,
    output logic                 req_wr_rdy,
    output logic                 ptr_rd_req_val,
    output logic [FLOWID_W-1:0]  ptr_rd_req_flowid,
    input  logic                 ptr_rd_req_rdy,
    input  logic                 ptr_rd_resp_val,
    input  logic [REQ_PTR_W:0]   ptr_rd_resp_head,
    input  logic [REQ_PTR_W:0]   ptr_rd_resp_tail,
    output logic                 ptr_rd_resp_rdy,
    output logic                 notif_val,
    output logic [FLOWID_W-1:0]  notif_flowid,
    output logic [REQ_PTR_W:0]   notif_addr,
    output logic [REQ_PTR_W-1:0] notif_len,
    output logic [XY_WIDTH-1:0]  notif_dst_x,
    output logic [XY_WIDTH-1:0]  notif_dst_y,
    output logic [FBITS_W-1:0]   notif_dst_fbits,
    input  logic                 notif_rdy
);
    localparam int NUM_FLOWS = 2**FLOWID_W;

    typedef struct packed {
        logic [REQ_PTR_W-1:0] len;
        logic [XY_WIDTH-1:0]  dst_x;
        logic [XY_WIDTH-1:0]  dst_y;
        logic [FBITS_W-1:0]   dst_fbits;
    } req_t;

    typedef enum logic [1:0] {SCAN, PTR_REQ, PTR_RESP, NOTIF} state_t;

    state_t               state, state_nx;
    req_t                 mem [NUM_FLOWS];
    req_t                 wr_ent, cur_ent;
    logic [NUM_FLOWS-1:0] pending, pend_nx;
    logic [FLOWID_W-1:0]  rr_ptr, rr_nx, cur_flow, sel;
    logic [REQ_PTR_W:0]   cur_head, avail;
    logic                 found, dirty, ok, wr_sel;

    assign wr_ent = {req_wr_len, req_wr_dst_x, req_wr_dst_y, req_wr_dst_fbits};
    assign avail  = ptr_rd_resp_tail - ptr_rd_resp_head;
    assign ok     = avail >= {1'b0, cur_ent.len};
    assign wr_sel = req_wr_val && req_wr_flowid == sel;

    assign req_wr_rdy        = rst_n;
    assign ptr_rd_req_val    = state == PTR_REQ;
    assign ptr_rd_req_flowid = cur_flow;
    assign ptr_rd_resp_rdy   = state == PTR_RESP;
    assign notif_val         = state == NOTIF;
    assign notif_flowid      = cur_flow;
    assign notif_addr        = cur_head;
    assign notif_len         = cur_ent.len;
    assign notif_dst_x       = cur_ent.dst_x;
    assign notif_dst_y       = cur_ent.dst_y;
    assign notif_dst_fbits   = cur_ent.dst_fbits;

    // request storage, written on every beat regardless of state
    always_ff @(posedge clk) begin
        if (req_wr_val) mem[req_wr_flowid] <= wr_ent;
    end

    // first pending flow at or after rr_ptr; descending loop lets the nearest index win
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
            if (pending[rr_ptr + FLOWID_W'(i)]) begin
                sel   = rr_ptr + FLOWID_W'(i);
                found = 1'b1;
            end
        end
    end

    // next state, rotation pointer and pending set; a same-cycle write always re-pends its flow
    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        pend_nx  = pending;
        case (state)
            SCAN:     if (found) state_nx = PTR_REQ;
            PTR_REQ:  if (ptr_rd_req_rdy) state_nx = PTR_RESP;
            PTR_RESP: if (ptr_rd_resp_val) begin
                state_nx = ok ? NOTIF : SCAN;
                rr_nx    = ok ? rr_ptr : cur_flow + 1'b1;
            end
            NOTIF:    if (notif_rdy) begin
                state_nx = SCAN;
                rr_nx    = cur_flow + 1'b1;
                if (!dirty) pend_nx[cur_flow] = 1'b0;
            end
        endcase
        if (req_wr_val) pend_nx[req_wr_flowid] = 1'b1;
    end

    // state registers and the latched copy of the flow under evaluation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SCAN;
            pending  <= '0;
            rr_ptr   <= '0;
            dirty    <= 1'b0;
            cur_flow <= '0;
            cur_ent  <= '0;
            cur_head <= '0;
        end else begin
            state   <= state_nx;
            pending <= pend_nx;
            rr_ptr  <= rr_nx;
            if (state == SCAN && found) begin
                cur_flow <= sel;
                cur_ent  <= wr_sel ? wr_ent : mem[sel];
                dirty    <= 1'b0;
            end else if (state != SCAN && req_wr_val && req_wr_flowid == cur_flow) begin
                dirty <= 1'b1;
            end
            if (state == PTR_RESP && ptr_rd_resp_val && ok) cur_head <= ptr_rd_resp_head;
        end
    end
endmodule

// File: tb/tb_tcp_msg_poll_sched.sv
// tb_tcp_msg_poll_sched: scoreboard bench for the per-flow poll scheduler
module tb_tcp_msg_poll_sched;
    localparam int FW = 3, PW = 16, XW = 8, BW = 4;

    typedef struct packed {
        logic [FW-1:0] flow;
        logic [PW:0]   addr;
        logic [PW-1:0] len;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [BW-1:0] fb;
    } notif_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_wr_val = 1'b0, req_wr_rdy;
    logic [FW-1:0] req_wr_flowid = '0;
    logic [PW-1:0] req_wr_len = '0;
    logic [XW-1:0] req_wr_dst_x = '0, req_wr_dst_y = '0;
    logic [BW-1:0] req_wr_dst_fbits = '0;
    logic          ptr_rd_req_val, ptr_rd_req_rdy = 1'b1;
    logic [FW-1:0] ptr_rd_req_flowid;
    logic          ptr_rd_resp_val = 1'b0, ptr_rd_resp_rdy;
    logic [PW:0]   ptr_rd_resp_head = '0, ptr_rd_resp_tail = '0;
    logic          notif_val, notif_rdy = 1'b1;
    logic [FW-1:0] notif_flowid;
    logic [PW:0]   notif_addr;
    logic [PW-1:0] notif_len;
    logic [XW-1:0] notif_dst_x, notif_dst_y;
    logic [BW-1:0] notif_dst_fbits;

    notif_t      exp_q[$];
    notif_t      obs;
    logic [PW:0] head_m [8];
    logic [PW:0] tail_m [8];
    int          n_cmp = 0, n_err = 0, rd_cnt = 0;

    assign obs = {notif_flowid, notif_addr, notif_len, notif_dst_x, notif_dst_y, notif_dst_fbits};

    always #5 clk = ~clk;

    tcp_msg_poll_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_wr_val(req_wr_val), .req_wr_flowid(req_wr_flowid), .req_wr_len(req_wr_len),
        .req_wr_dst_x(req_wr_dst_x), .req_wr_dst_y(req_wr_dst_y), .req_wr_dst_fbits(req_wr_dst_fbits),
        .req_wr_rdy(req_wr_rdy),
        .ptr_rd_req_val(ptr_rd_req_val), .ptr_rd_req_flowid(ptr_rd_req_flowid), .ptr_rd_req_rdy(ptr_rd_req_rdy),
        .ptr_rd_resp_val(ptr_rd_resp_val), .ptr_rd_resp_head(ptr_rd_resp_head),
        .ptr_rd_resp_tail(ptr_rd_resp_tail), .ptr_rd_resp_rdy(ptr_rd_resp_rdy),
        .notif_val(notif_val), .notif_flowid(notif_flowid), .notif_addr(notif_addr), .notif_len(notif_len),
        .notif_dst_x(notif_dst_x), .notif_dst_y(notif_dst_y), .notif_dst_fbits(notif_dst_fbits),
        .notif_rdy(notif_rdy)
    );

    function automatic notif_t mk(input logic [FW-1:0] f, input logic [PW:0] a, input logic [PW-1:0] l,
                                  input logic [XW-1:0] x, input logic [XW-1:0] y, input logic [BW-1:0] b);
        return {f, a, l, x, y, b};
    endfunction

    // pointer memory model: answers each accepted read one cycle later from head_m/tail_m
    initial begin
        logic [FW-1:0] f;
        forever begin
            @(negedge clk); #1;
            if (ptr_rd_req_val && ptr_rd_req_rdy) begin
                rd_cnt++;
                f = ptr_rd_req_flowid;
                @(negedge clk); #1;
                ptr_rd_resp_val  = 1'b1;
                ptr_rd_resp_head = head_m[f];
                ptr_rd_resp_tail = tail_m[f];
                @(negedge clk); #1;
                ptr_rd_resp_val = 1'b0;
            end
        end
    end

    // scoreboard: every valid notification must match the queue head, popped on handshake
    initial begin
        forever begin
            @(negedge clk); #1;
            if (notif_val) begin
                if (exp_q.size() == 0) begin
                    if (notif_rdy) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_notif: got flow %0d len %0d, required none", notif_flowid, notif_len);
                    end
                end else begin
                    n_cmp++;
                    if (obs !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL notif: got %h, required %h", obs, exp_q[0]);
                    end
                    if (notif_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wr(input logic [FW-1:0] f, input logic [PW-1:0] l, input logic [XW-1:0] x,
                      input logic [XW-1:0] y, input logic [BW-1:0] b);
        req_wr_val       = 1'b1;
        req_wr_flowid    = f;
        req_wr_len       = l;
        req_wr_dst_x     = x;
        req_wr_dst_y     = y;
        req_wr_dst_fbits = b;
        @(negedge clk);
        req_wr_val = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({notif_val, ptr_rd_req_val, ptr_rd_resp_rdy, req_wr_rdy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 0000", {notif_val, ptr_rd_req_val, ptr_rd_resp_rdy, req_wr_rdy});
        end
        n_cmp++;
        if ({ptr_rd_req_flowid, obs} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h, required 0", {ptr_rd_req_flowid, obs});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_wr_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_rdy: got %b, required 1", req_wr_rdy);
        end
    endtask

    task automatic test_basic;
        int c;
        head_m[2] = 17'h10;
        tail_m[2] = 17'h80;
        exp_q.push_back(mk(3'd2, 17'h10, 16'd100, 8'd1, 8'd3, 4'd5));
        wr(3'd2, 16'd100, 8'd1, 8'd3, 4'd5);
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_timeout: got %0d left, required 0", exp_q.size());
        end
        c = rd_cnt;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rd_cnt != c) begin
            n_err++;
            $display("FAIL basic_cleared: got %0d reads, required 0", rd_cnt - c);
        end
    endtask

    task automatic test_insufficient;
        int c;
        head_m[5] = 17'h0;
        tail_m[5] = 17'd63;
        c = rd_cnt;
        wr(3'd5, 16'd64, 8'd4, 8'd4, 4'd2);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rd_cnt - c < 2) begin
            n_err++;
            $display("FAIL short_revisit: got %0d reads, required >=2", rd_cnt - c);
        end
        exp_q.push_back(mk(3'd5, 17'h0, 16'd64, 8'd4, 8'd4, 4'd2));
        tail_m[5] = 17'd64;
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL short_timeout: got %0d left, required 0", exp_q.size());
        end
        c = rd_cnt;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rd_cnt != c) begin
            n_err++;
            $display("FAIL short_cleared: got %0d reads, required 0", rd_cnt - c);
        end
    endtask

    task automatic test_wrap;
        int c;
        head_m[0] = 17'h1FFF0;
        tail_m[0] = 17'h00010;
        exp_q.push_back(mk(3'd0, 17'h1FFF0, 16'h20, 8'd7, 8'd8, 4'd9));
        wr(3'd0, 16'h20, 8'd7, 8'd8, 4'd9);
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_exact: got %0d left, required 0", exp_q.size());
        end
        c = rd_cnt;
        wr(3'd0, 16'h21, 8'd7, 8'd8, 4'd9);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rd_cnt - c < 2) begin
            n_err++;
            $display("FAIL wrap_short: got %0d reads, required >=2", rd_cnt - c);
        end
        exp_q.push_back(mk(3'd0, 17'h1FFF0, 16'h21, 8'd7, 8'd8, 4'd9));
        tail_m[0] = 17'h00011;
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_plus1: got %0d left, required 0", exp_q.size());
        end
        head_m[7] = 17'd5;
        tail_m[7] = 17'd5;
        exp_q.push_back(mk(3'd7, 17'd5, 16'd0, 8'd2, 8'd6, 4'd1));
        wr(3'd7, 16'd0, 8'd2, 8'd6, 4'd1);
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL zero_len: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_order;
        int i;
        test_reset();
        head_m[1] = 17'h20;  tail_m[1] = 17'h40;
        head_m[3] = 17'h100; tail_m[3] = 17'h180;
        head_m[6] = 17'h300; tail_m[6] = 17'h310;
        exp_q.push_back(mk(3'd1, 17'h20, 16'd10, 8'd1, 8'd1, 4'd1));
        exp_q.push_back(mk(3'd3, 17'h100, 16'd30, 8'd3, 8'd3, 4'd3));
        exp_q.push_back(mk(3'd6, 17'h300, 16'd16, 8'd6, 8'd6, 4'd6));
        wr(3'd1, 16'd10, 8'd1, 8'd1, 4'd1);
        wr(3'd3, 16'd30, 8'd3, 8'd3, 4'd3);
        wr(3'd6, 16'd16, 8'd6, 8'd6, 4'd6);
        for (i = 0; i < 100 && !(ptr_rd_resp_rdy && ptr_rd_req_flowid == 3'd3); i++) @(negedge clk);
        n_cmp++;
        if (!(ptr_rd_resp_rdy && ptr_rd_req_flowid == 3'd3)) begin
            n_err++;
            $display("FAIL order_sync: got flow %0d resp_rdy %b, required flow 3 resp_rdy 1", ptr_rd_req_flowid, ptr_rd_resp_rdy);
        end
        exp_q.push_back(mk(3'd1, 17'h20, 16'd20, 8'd11, 8'd12, 4'd13));
        wr(3'd1, 16'd20, 8'd11, 8'd12, 4'd13);
        drain(200);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL order_timeout: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_dirty;
        int i;
        head_m[4] = 17'h100;
        tail_m[4] = 17'h200;
        notif_rdy = 1'b0;
        exp_q.push_back(mk(3'd4, 17'h100, 16'd20, 8'd2, 8'd2, 4'd1));
        exp_q.push_back(mk(3'd4, 17'h100, 16'd8, 8'd9, 8'd9, 4'd9));
        wr(3'd4, 16'd20, 8'd2, 8'd2, 4'd1);
        for (i = 0; i < 100 && !notif_val; i++) @(negedge clk);
        n_cmp++;
        if (notif_val !== 1'b1) begin
            n_err++;
            $display("FAIL dirty_wait: got notif_val %b, required 1", notif_val);
        end
        wr(3'd4, 16'd8, 8'd9, 8'd9, 4'd9);
        repeat (2) @(negedge clk);
        notif_rdy = 1'b1;
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL dirty_timeout: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_notif;
        int i, c;
        notif_rdy = 1'b0;
        wr(3'd2, 16'd4, 8'd5, 8'd5, 4'd5);
        wr(3'd3, 16'd4, 8'd5, 8'd5, 4'd5);
        for (i = 0; i < 100 && !notif_val; i++) @(negedge clk);
        n_cmp++;
        if (notif_val !== 1'b1) begin
            n_err++;
            $display("FAIL rstn_wait: got notif_val %b, required 1", notif_val);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({notif_val, ptr_rd_req_val, ptr_rd_resp_rdy, req_wr_rdy} !== 4'b0) begin
            n_err++;
            $display("FAIL rstn_ctrl: got %b, required 0000", {notif_val, ptr_rd_req_val, ptr_rd_resp_rdy, req_wr_rdy});
        end
        n_cmp++;
        if ({ptr_rd_req_flowid, obs} !== '0) begin
            n_err++;
            $display("FAIL rstn_data: got %h, required 0", {ptr_rd_req_flowid, obs});
        end
        rst_n = 1'b1;
        notif_rdy = 1'b1;
        c = rd_cnt;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (rd_cnt != c) begin
            n_err++;
            $display("FAIL rstn_idle: got %0d reads, required 0", rd_cnt - c);
        end
        exp_q.push_back(mk(3'd2, 17'h10, 16'd50, 8'd1, 8'd2, 4'd3));
        wr(3'd2, 16'd50, 8'd1, 8'd2, 4'd3);
        drain(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rstn_resume: got %0d left, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            head_m[i] = '0;
            tail_m[i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_insufficient();
        test_wrap();
        test_order();
        test_dirty();
        test_reset_notif();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tcp_msg_poll_sched.md
Name: tcp_msg_poll_sched

Overview:
- Per-flow scheduler for the TCP message poller.
- Stores one outstanding message request per flow: length, dst_x, dst_y, dst_fbits, in the same packed layout as the poller's request-memory struct.
- Visits pending flows round-robin, reads each flow's head/tail buffer pointers, and issues a notification once enough bytes are buffered to satisfy the requested length.
- Sits between the app-side request interface and the NoC notification sender, sharing one pointer-read port across all flows.

Parameters:
- FLOWID_W, 3: flow id width; NUM_FLOWS = 2**FLOWID_W.
- REQ_PTR_W, 16: request length width; buffer pointers are REQ_PTR_W+1 bits, the MSB being the wrap bit.
- XY_WIDTH, 8: NoC coordinate width.
- FBITS_W, 4: NoC fbits width.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous, active-low reset.
- req_wr_val in 1: request write valid.
- req_wr_flowid in FLOWID_W: flow being written.
- req_wr_len in REQ_PTR_W: requested byte length.
- req_wr_dst_x in XY_WIDTH: destination x.
- req_wr_dst_y in XY_WIDTH: destination y.
- req_wr_dst_fbits in FBITS_W: destination fbits.
- req_wr_rdy out 1: always 1 outside reset.
- ptr_rd_req_val out 1: pointer read request valid.
- ptr_rd_req_flowid out FLOWID_W: flow whose pointers are read.
- ptr_rd_req_rdy in 1: pointer read request ready.
- ptr_rd_resp_val in 1: pointer read response valid.
- ptr_rd_resp_head in REQ_PTR_W+1: flow head pointer.
- ptr_rd_resp_tail in REQ_PTR_W+1: flow tail pointer.
- ptr_rd_resp_rdy out 1: pointer read response ready.
- notif_val out 1: notification valid.
- notif_flowid out FLOWID_W: notified flow.
- notif_addr out REQ_PTR_W+1: head pointer at evaluation.
- notif_len out REQ_PTR_W: satisfied length.
- notif_dst_x out XY_WIDTH: destination x.
- notif_dst_y out XY_WIDTH: destination y.
- notif_dst_fbits out FBITS_W: destination fbits.
- notif_rdy in 1: notification ready.

Behaviour:
- Storage:
  - Request array of NUM_FLOWS entries, plus pending[NUM_FLOWS] and a rotating pointer rr_ptr.
  - A req_wr_val beat writes the entry and sets pending[flowid] in the same cycle, in every state.
- Reset (rst_n=0 at a clk edge):
  - pending, rr_ptr and dirty are cleared; state becomes SCAN.
  - All *_val outputs, ptr_rd_resp_rdy and req_wr_rdy are 0.
  - Data outputs are 0. Array contents are don't-care.
  - Reset mid-transaction abandons it; no notification is issued afterwards.
- State SCAN:
  - Select the first pending flow at index >= rr_ptr, wrapping modulo NUM_FLOWS.
  - Latch its flowid and entry (using the array value after any same-cycle write), clear dirty, go to PTR_REQ.
  - If no flow is pending, stay in SCAN.
  - Latency is 1 cycle from pending set to SCAN selection.
- State PTR_REQ:
  - ptr_rd_req_val=1 with the latched flowid.
  - On ptr_rd_req_rdy, go to PTR_RESP.
- State PTR_RESP:
  - ptr_rd_resp_rdy=1.
  - On ptr_rd_resp_val, compute avail = (tail - head) mod 2^(REQ_PTR_W+1).
  - If avail >= zero-extended latched length, latch head and go to NOTIF.
  - Otherwise set rr_ptr = flowid+1 (wrapping), leave pending set, go to SCAN.
  - Length 0 always satisfies.
- State NOTIF:
  - notif_val=1; outputs hold stable until notif_rdy.
  - On handshake, clear pending[flowid] unless dirty, or unless a same-cycle write targets this flow.
  - Set rr_ptr = flowid+1 and go to SCAN.
- dirty:
  - Set by any req_wr to the latched flowid while in PTR_REQ, PTR_RESP or NOTIF.
  - The in-flight evaluation keeps the latched copy; the new request stays pending and is re-evaluated later.
- Fairness: a flow that fails the check or is notified is not revisited until every other pending flow has been visited once.
- Single outstanding pointer read; no pipelining across flows.

Test Plan:
1. Reset, then write flow 2 with len=100, dst (1,3), fbits=5. Pointers return head=0x10, tail=0x80 (avail 112). Required: one notif with flow 2, addr 0x10, len 100, dst (1,3,5); pending[2] then clears.
2. Flow 5 with len=64 and avail=63 -> no notif, flow revisited. Raise tail by 1 -> notif issued on the next visit.
3. Pointer wrap: head=0x1FFF0, tail=0x00010 with REQ_PTR_W=16 gives avail=0x20. len=0x20 -> notif; len=0x21 -> none.
4. Flows 1, 3 and 6 pending, all satisfied, rr_ptr=0, notif_rdy held high -> notif order 1, 3, 6. Then re-pend flow 1 while flow 3 is in PTR_RESP -> order continues 6, then 1.
5. Rewrite flow 4 with len=8 while flow 4 is in NOTIF and notif_rdy is stalled 3 cycles. Required: the original len is notified, pending[4] stays set, and a second notif with len=8 follows.
6. Assert rst_n low while in NOTIF -> notif_val=0 the next cycle, all pending cleared, no notifications afterwards until new writes.
